// File: rtl/mips_div_pkg.sv
// ============================================================================
// Module      : mips_div_pkg
// Description : Shared types, constants and helpers for the MIPS DIV/DIVU
//               iterative divider (state encoding, magnitude helper, counter
//               width helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_div_pkg;

  // Default operand width of the MIPS integer datapath.
  localparam int DIV_WIDTH = 32;

  // Divider control states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Bits needed to count 0..w iterations.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Magnitude of a w-bit value held in the low bits of v. When sgn is 0 the
  // value is returned unchanged; the most-negative value maps to 2^(w-1),
  // which still fits in w unsigned bits.
  function automatic logic [63:0] abs_val(input logic [63:0] v, input int w,
                                          input logic sgn);
    logic [63:0] mask;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    if (sgn && v[w-1])
      return ((~v) + 64'd1) & mask;
    return v & mask;
  endfunction

endpackage : mips_div_pkg

`default_nettype wire

// File: rtl/mips_divider_div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division iteration. Shifts the
//               {rem,quo} pair left by one, trial-subtracts the divisor and
//               restores when the trial goes negative.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] w_shift_rem;
  logic [WIDTH:0] w_trial;

  // The extra remainder bit keeps the trial subtraction's sign visible.
  assign w_shift_rem = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign w_trial     = w_shift_rem - {1'b0, divisor};

  // Keep the trial result when non-negative, otherwise restore.
  always_comb begin
    rem_next = w_shift_rem;
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH]) begin
      rem_next = w_trial;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step

`default_nettype wire

// File: rtl/mips_divider.sv
// ============================================================================
// Module      : mips_divider
// Description : Multi-cycle restoring divider for MIPS DIV/DIVU. Quotient is
//               returned in lo, remainder in hi. Constant WIDTH+1 cycle
//               latency; abort cancels an in-flight operation.
//               Optional macro MIPS_DIV_EARLY_ZERO_EN: a zero divisor skips
//               the iteration phase and completes one edge after start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0]  c_last = CW'(WIDTH - 1);

  div_state_t       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_op1;
  logic             r_neg_q, r_neg_r, r_zero;
  logic             r_done, r_div_zero;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_mag1, w_mag2;
  logic             w_accept, w_skip;

  // A simultaneous abort suppresses a new request.
  assign w_accept = start && !abort;
  assign w_mag1   = WIDTH'(abs_val(64'(op1), WIDTH, !is_unsigned));
  assign w_mag2   = WIDTH'(abs_val(64'(op2), WIDTH, !is_unsigned));

`ifdef MIPS_DIV_EARLY_ZERO_EN
  assign w_skip = (op2 == '0);
`else
  assign w_skip = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_div),
    .rem_next (w_rem_nx),
    .quo_next (w_quo_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort returns any busy state to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_skip ? FIX : CALC;
      CALC:    if (r_cnt == c_last) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort && (r_state != IDLE)) w_next = IDLE;
  end

  // Operand capture, iteration and result sign fix-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_op1      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_zero     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_mag1;
            r_div   <= w_mag2;
            r_op1   <= op1;
            r_neg_q <= !is_unsigned && (op1[WIDTH-1] ^ op2[WIDTH-1]);
            r_neg_r <= !is_unsigned && op1[WIDTH-1];
            r_zero  <= (op2 == '0);
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          if (!abort) begin
            r_done     <= 1'b1;
            r_div_zero <= r_zero;
            if (r_zero) begin
              r_lo <= '1;
              r_hi <= r_op1;
            end else begin
              r_lo <= r_neg_q ? -r_quo : r_quo;
              r_hi <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule : mips_divider

`default_nettype wire

// File: tb/tb_mips_divider.sv
// ============================================================================
// Module      : tb_mips_divider
// Description : Scoreboard bench for mips_divider. Stimulus pushes expected
//               results (from plain integer arithmetic) with the cycle they
//               are due; a monitor pops and compares on every done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_divider;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, is_unsigned = 1'b0, abort = 1'b0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mips_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_unsigned(is_unsigned),
    .op1(op1), .op2(op2), .abort(abort), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  int           n_checks = 0, n_pass = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;
  logic         last_dz = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endfunction

  // Reference: MIPS semantics from integer division (truncating toward zero).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic u, input int c0);
    exp_t   e;
    longint sa, sb;
    e.dz = (b == 0);
    if (b == 0) begin
      e.lo = '1;
      e.hi = a;
    end else if (u) begin
      e.lo = a / b;
      e.hi = a % b;
    end else begin
      sa   = $signed(a);
      sb   = $signed(b);
      e.lo = W'(sa / sb);
      e.hi = W'(sa % sb);
    end
`ifdef MIPS_DIV_EARLY_ZERO_EN
    e.due = c0 + ((b == 0) ? 1 : LAT);
`else
    e.due = c0 + LAT;
`endif
    return e;
  endfunction

  // Called at a negedge while idle; returns at the negedge after the start edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
    start = 1'b1; op1 = a; op2 = b; is_unsigned = u;
    sbq.push_back(model(a, b, u, cyc + 1));
    @(negedge clk);
    start = 1'b0; op1 = $urandom; op2 = $urandom; is_unsigned = $urandom_range(0, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  // Monitor: compare results on done, otherwise check outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("lo", lo, e.lo);
          chk("hi", hi, e.hi);
          chk("div_zero", div_zero, e.dz);
          chk("latency", cyc, e.due);
          last_hi = e.hi; last_lo = e.lo; last_dz = e.dz;
        end
      end else begin
        chk("hold_hi", hi, last_hi);
        chk("hold_lo", lo, last_lo);
        chk("hold_dz", div_zero, last_dz);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [W-1:0] a, b;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned 100/7 with busy-length measurement.
    issue(32'd100, 32'd7, 1'b1);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, LAT);

    // Directed corner cases, issued back-to-back on each done cycle.
    issue(32'hFFFF_FFF9, 32'd2, 1'b0);         wait_idle();
    chk("b2b_on_done", done, 1);
    issue(32'd7, 32'hFFFF_FFFE, 1'b0);         wait_idle();
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);         wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
    issue(32'h1234_5678, 32'd0, 1'b0);         wait_idle();
    issue(32'h8765_4321, 32'd0, 1'b1);         wait_idle();
    issue(32'hFFFF_FFF0, 32'd0, 1'b0);         wait_idle();

    // Abort mid-calculation: no done, previous results held.
    issue(32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    void'(sbq.pop_back());
    chk("abort_busy", busy, 0);
    repeat (40) @(negedge clk);

    // Start pulsed while busy must be ignored.
    issue(32'd1000, 32'd3, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; op1 = 32'd5; op2 = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-calculation.
    issue(32'd100, 32'd7, 1'b1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    last_hi = '0; last_lo = '0; last_dz = 1'b0;
    sbq.delete();
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_dz", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized operations with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        2: begin a = $urandom; b = '0; end
        3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1; end
        default: begin a = $urandom; b = W'($signed($urandom_range(0, 30)) - 15); end
      endcase
      issue(a, b, $urandom_range(0, 1) != 0);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mips_divider

`default_nettype wire
